// File: rtl/tomasulo_issue_unit_pkg.sv
// Shared definitions for the Tomasulo issue stage: class encodings, opcodes
// and the opcode-to-class decoder.
package tomasulo_pkg;

  localparam int unsigned CLS_W      = 2;
  localparam int unsigned FUNC_MAX_W = 16;
  localparam int unsigned CRED_W     = 4;

  typedef enum logic [CLS_W-1:0] {
    CLS_ADD  = 2'd0,
    CLS_MUL  = 2'd1,
    CLS_BCH  = 2'd2,
    CLS_NONE = 2'd3
  } cls_e;

  localparam logic [FUNC_MAX_W-1:0] OP_ADD0 = 16'h0000;
  localparam logic [FUNC_MAX_W-1:0] OP_ADD1 = 16'h0001;
  localparam logic [FUNC_MAX_W-1:0] OP_MUL0 = 16'h0002;
  localparam logic [FUNC_MAX_W-1:0] OP_MUL1 = 16'h0003;
  localparam logic [FUNC_MAX_W-1:0] OP_BCH0 = 16'h0004;
  localparam logic [FUNC_MAX_W-1:0] OP_BCH1 = 16'h0005;

  typedef struct packed {
    logic legal;
    cls_e cls;
  } func_dec_t;

  // Callers zero-extend the opcode to FUNC_MAX_W before decoding.
  function automatic func_dec_t func_class(input logic [FUNC_MAX_W-1:0] func);
    func_dec_t d;
    d.legal = 1'b1;
    d.cls   = CLS_NONE;
    case (func)
      OP_ADD0, OP_ADD1: d.cls = CLS_ADD;
      OP_MUL0, OP_MUL1: d.cls = CLS_MUL;
      OP_BCH0, OP_BCH1: d.cls = CLS_BCH;
      default:          d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tomasulo_issue_unit_if.sv
// Decode-to-dispatch bus of the issue stage: instruction handshake in,
// registered dispatch packet out.
interface tomasulo_issue_unit_if #(
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned FUNC_W    = 4,
  parameter int unsigned ROB_DEPTH = 8
);
  localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
  localparam int unsigned OPR_W = (REG_AW > TAG_W) ? REG_AW : TAG_W;

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic [FUNC_W-1:0] in_func;

  logic              out_valid;
  logic [1:0]        out_class;
  logic              out_rs1_busy;
  logic              out_rs2_busy;
  logic [OPR_W-1:0]  out_rs1;
  logic [OPR_W-1:0]  out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic [FUNC_W-1:0] out_func;
  logic [TAG_W-1:0]  out_tag;
  logic              illegal;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_func,
    input  in_ready,
    input  out_valid, out_class, out_rs1_busy, out_rs2_busy,
    input  out_rs1, out_rs2, out_rd, out_func, out_tag, illegal
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_func,
    output in_ready,
    output out_valid, out_class, out_rs1_busy, out_rs2_busy,
    output out_rs1, out_rs2, out_rd, out_func, out_tag, illegal
  );

endinterface

// File: rtl/tomasulo_issue_unit_credit.sv
// Per-class reservation-station credit counter: saturating at MAX,
// refilled by flush or reset.
module issue_credit_ctr
  import tomasulo_pkg::*;
#(
  parameter int unsigned MAX = 3
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic alloc,
  input  logic rel,
  input  logic flush,
  output logic has_credit
);

  logic [CRED_W-1:0] cnt;

  // Alloc and release in the same cycle cancel out.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CRED_W'(MAX);
    end else if (flush) begin
      cnt <= CRED_W'(MAX);
    end else if (alloc && !rel && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (rel && !alloc && cnt != CRED_W'(MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign has_credit = (cnt != '0);

endmodule

// File: rtl/tomasulo_issue_unit.sv
// Tomasulo issue stage: ROB tag allocation, RAT renaming, RS credit checks
// and a registered dispatch packet.
module tomasulo_issue_unit
  import tomasulo_pkg::*;
#(
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned FUNC_W    = 4,
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned ADD_RS    = 3,
  parameter int unsigned MUL_RS    = 3,
  parameter int unsigned BCH_RS    = 3
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  tomasulo_issue_unit_if.slave         iss,
  input  logic                         commit_valid,
  input  logic [REG_AW-1:0]            commit_rd,
  input  logic                         commit_wr,
  input  logic                         rel_add,
  input  logic                         rel_mul,
  input  logic                         rel_bch,
  input  logic                         flush,
  output logic [$clog2(ROB_DEPTH):0]   rob_count
);

  localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned OPR_W = (REG_AW > TAG_W) ? REG_AW : TAG_W;
  localparam int unsigned NREG  = 2 ** REG_AW;

  logic [NREG-1:0]  rat_busy;
  logic [TAG_W-1:0] rat_tag [NREG];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  func_dec_t        dec_c;
  logic             cred_add_c, cred_mul_c, cred_bch_c, cls_credit_c;
  logic             rob_full_c, accept_c, issue_c, bad_op_c, commit_ok_c, rename_c;
  logic             alloc_add_c, alloc_mul_c, alloc_bch_c;
  logic [TAG_W-1:0] rs1_tag_c, rs2_tag_c;
  logic             rs1_busy_c, rs2_busy_c, rs1_byp_c, rs2_byp_c;

  assign dec_c = func_class(FUNC_MAX_W'(iss.in_func));

  always_comb begin
    cls_credit_c = 1'b0;
    case (dec_c.cls)
      CLS_ADD: cls_credit_c = cred_add_c;
      CLS_MUL: cls_credit_c = cred_mul_c;
      CLS_BCH: cls_credit_c = cred_bch_c;
      default: cls_credit_c = 1'b0;
    endcase
  end

  // Reserved opcodes are swallowed regardless of ROB or credit state.
  assign rob_full_c   = (rob_count == CNT_W'(ROB_DEPTH));
  assign iss.in_ready = !flush && (!dec_c.legal || (!rob_full_c && cls_credit_c));
  assign accept_c     = iss.in_valid && iss.in_ready;
  assign issue_c      = accept_c && dec_c.legal;
  assign bad_op_c     = accept_c && !dec_c.legal;
  assign commit_ok_c  = commit_valid && (rob_count != '0) && !flush;
  assign rename_c     = issue_c && (dec_c.cls != CLS_BCH);

  assign alloc_add_c  = issue_c && (dec_c.cls == CLS_ADD);
  assign alloc_mul_c  = issue_c && (dec_c.cls == CLS_MUL);
  assign alloc_bch_c  = issue_c && (dec_c.cls == CLS_BCH);

  // Operands see the RAT before this cycle's rename; a retiring producer is bypassed.
  assign rs1_tag_c  = rat_tag[iss.in_rs1];
  assign rs2_tag_c  = rat_tag[iss.in_rs2];
  assign rs1_byp_c  = commit_ok_c && commit_wr && (commit_rd == iss.in_rs1) && (rs1_tag_c == head);
  assign rs2_byp_c  = commit_ok_c && commit_wr && (commit_rd == iss.in_rs2) && (rs2_tag_c == head);
  assign rs1_busy_c = rat_busy[iss.in_rs1] && !rs1_byp_c;
  assign rs2_busy_c = rat_busy[iss.in_rs2] && !rs2_byp_c;

  issue_credit_ctr #(.MAX(ADD_RS)) u_cred_add (
    .clk1(clk1), .rst_n(rst_n), .alloc(alloc_add_c), .rel(rel_add),
    .flush(flush), .has_credit(cred_add_c)
  );

  issue_credit_ctr #(.MAX(MUL_RS)) u_cred_mul (
    .clk1(clk1), .rst_n(rst_n), .alloc(alloc_mul_c), .rel(rel_mul),
    .flush(flush), .has_credit(cred_mul_c)
  );

  issue_credit_ctr #(.MAX(BCH_RS)) u_cred_bch (
    .clk1(clk1), .rst_n(rst_n), .alloc(alloc_bch_c), .rel(rel_bch),
    .flush(flush), .has_credit(cred_bch_c)
  );

  // RAT: the later rename assignment overrides a same-cycle commit clear.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rat_busy <= '0;
      for (int i = 0; i < NREG; i++) rat_tag[i] <= '0;
    end else if (flush) begin
      rat_busy <= '0;
    end else begin
      if (commit_ok_c && commit_wr && rat_tag[commit_rd] == head) begin
        rat_busy[commit_rd] <= 1'b0;
      end
      if (rename_c) begin
        rat_busy[iss.in_rd] <= 1'b1;
        rat_tag[iss.in_rd]  <= tail;
      end
    end
  end

  // ROB pointers; occupancy is counted so a full ROB is distinct from empty.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      rob_count <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      rob_count <= '0;
    end else begin
      if (issue_c)     tail <= tail + 1'b1;
      if (commit_ok_c) head <= head + 1'b1;
      case ({issue_c, commit_ok_c})
        2'b10:   rob_count <= rob_count + 1'b1;
        2'b01:   rob_count <= rob_count - 1'b1;
        default: rob_count <= rob_count;
      endcase
    end
  end

  // Dispatch packet: pulses are single-cycle, fields hold until the next issue.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss.out_valid    <= 1'b0;
      iss.illegal      <= 1'b0;
      iss.out_class    <= '0;
      iss.out_rs1_busy <= 1'b0;
      iss.out_rs2_busy <= 1'b0;
      iss.out_rs1      <= '0;
      iss.out_rs2      <= '0;
      iss.out_rd       <= '0;
      iss.out_func     <= '0;
      iss.out_tag      <= '0;
    end else if (flush) begin
      iss.out_valid <= 1'b0;
      iss.illegal   <= 1'b0;
    end else begin
      iss.out_valid <= issue_c;
      iss.illegal   <= bad_op_c;
      if (issue_c) begin
        iss.out_class    <= dec_c.cls;
        iss.out_rs1_busy <= rs1_busy_c;
        iss.out_rs2_busy <= rs2_busy_c;
        iss.out_rs1      <= rs1_busy_c ? OPR_W'(rs1_tag_c) : OPR_W'(iss.in_rs1);
        iss.out_rs2      <= rs2_busy_c ? OPR_W'(rs2_tag_c) : OPR_W'(iss.in_rs2);
        iss.out_rd       <= iss.in_rd;
        iss.out_func     <= iss.in_func;
        iss.out_tag      <= tail;
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_issue_unit.sv
// Directed bench for tomasulo_issue_unit: rename, credits, ROB wrap,
// commit bypass, reserved opcodes, flush and asynchronous reset.
module tb_tomasulo_issue_unit;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       commit_valid, commit_wr, rel_add, rel_mul, rel_bch, flush;
  logic [3:0] commit_rd;
  logic [3:0] rob_count;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         mix [8] = '{0, 2, 4, 1, 3, 5, 0, 2};

  always #5 clk1 = ~clk1;

  tomasulo_issue_unit_if #(.REG_AW(4), .FUNC_W(4), .ROB_DEPTH(8)) iss ();

  tomasulo_issue_unit #(
    .REG_AW(4), .FUNC_W(4), .ROB_DEPTH(8), .ADD_RS(3), .MUL_RS(3), .BCH_RS(3)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .iss(iss),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_wr(commit_wr),
    .rel_add(rel_add), .rel_mul(rel_mul), .rel_bch(rel_bch),
    .flush(flush), .rob_count(rob_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    iss.in_valid = 1'b0;
    commit_valid = 1'b0;
    commit_wr    = 1'b0;
    commit_rd    = 4'd0;
    rel_add      = 1'b0;
    rel_mul      = 1'b0;
    rel_bch      = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic set_op(input int f, input int rd, input int rs1, input int rs2);
    iss.in_valid = 1'b1;
    iss.in_func  = 4'(f);
    iss.in_rd    = 4'(rd);
    iss.in_rs1   = 4'(rs1);
    iss.in_rs2   = 4'(rs2);
  endtask

  task automatic do_reset();
    idle();
    iss.in_func = 4'd0;
    cyc();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    set_op(0, 0, 0, 0);
    iss.in_valid = 1'b0;
    #12;
    chk("rst_valid", 32'(iss.out_valid), 0);
    chk("rst_illegal", 32'(iss.illegal), 0);
    chk("rst_count", 32'(rob_count), 0);
    chk("rst_tag", 32'(iss.out_tag), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(iss.in_ready), 1);

    // ADD r3 <- r1,r2 then MUL r4 <- r3,r3
    cyc();
    set_op(0, 3, 1, 2);
    #1 chk("s1_ready", 32'(iss.in_ready), 1);
    cyc();
    chk("s1_valid", 32'(iss.out_valid), 1);
    chk("s1_tag", 32'(iss.out_tag), 0);
    chk("s1_b1", 32'(iss.out_rs1_busy), 0);
    chk("s1_b2", 32'(iss.out_rs2_busy), 0);
    chk("s1_rs1", 32'(iss.out_rs1), 1);
    chk("s1_rs2", 32'(iss.out_rs2), 2);
    chk("s1_class", 32'(iss.out_class), 0);
    chk("s1_count", 32'(rob_count), 1);
    set_op(2, 4, 3, 3);
    cyc();
    chk("s1m_valid", 32'(iss.out_valid), 1);
    chk("s1m_tag", 32'(iss.out_tag), 1);
    chk("s1m_b1", 32'(iss.out_rs1_busy), 1);
    chk("s1m_b2", 32'(iss.out_rs2_busy), 1);
    chk("s1m_rs1", 32'(iss.out_rs1), 0);
    chk("s1m_rs2", 32'(iss.out_rs2), 0);
    chk("s1m_class", 32'(iss.out_class), 1);
    chk("s1m_count", 32'(rob_count), 2);
    idle();
    cyc();
    chk("s1_pulse", 32'(iss.out_valid), 0);
    chk("s1_hold", 32'(iss.out_tag), 1);

    // add credits: three issue, fourth stalls until rel_add
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_op(0, 5, 1, 1);
      cyc();
      chk("s2_tag", 32'(iss.out_tag), 32'(i));
    end
    set_op(0, 6, 1, 1);
    #1 chk("s2_stall", 32'(iss.in_ready), 0);
    rel_add = 1'b1;
    cyc();
    rel_add = 1'b0;
    chk("s2_noiss", 32'(iss.out_valid), 0);
    #1 chk("s2_ready", 32'(iss.in_ready), 1);
    cyc();
    chk("s2_valid", 32'(iss.out_valid), 1);
    chk("s2_tag4", 32'(iss.out_tag), 3);
    idle();

    // fill the ROB with mixed ops, then commit and wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_op(mix[i], i, 0, 0);
      rel_add = (mix[i] < 2);
      rel_mul = (mix[i] == 2 || mix[i] == 3);
      rel_bch = (mix[i] >= 4);
      cyc();
      chk("s3_tag", 32'(iss.out_tag), 32'(i));
    end
    rel_add = 1'b0; rel_mul = 1'b0; rel_bch = 1'b0;
    chk("s3_full", 32'(rob_count), 8);
    set_op(0, 1, 0, 0);
    #1 chk("s3_fullrdy", 32'(iss.in_ready), 0);
    set_op(15, 1, 0, 0);
    #1 chk("s3_illrdy", 32'(iss.in_ready), 1);
    cyc();
    chk("s3_ill", 32'(iss.illegal), 1);
    chk("s3_illv", 32'(iss.out_valid), 0);
    chk("s3_illcnt", 32'(rob_count), 8);
    set_op(0, 1, 0, 0);
    commit_valid = 1'b1;
    #1 chk("s3_cmtrdy", 32'(iss.in_ready), 0);
    cyc();
    chk("s3_cnt7", 32'(rob_count), 7);
    chk("s3_illoff", 32'(iss.illegal), 0);
    chk("s3_nov", 32'(iss.out_valid), 0);
    iss.in_valid = 1'b0;
    cyc();
    cyc();
    commit_valid = 1'b0;
    chk("s3_cnt5", 32'(rob_count), 5);
    for (int i = 0; i < 3; i++) begin
      set_op(0, 9, 0, 0);
      rel_add = 1'b1;
      cyc();
      chk("s3_wrap", 32'(iss.out_tag), 32'(i));
    end
    idle();
    chk("s3_refull", 32'(rob_count), 8);

    // commit bypass and RAT clear on commit
    do_reset();
    set_op(0, 3, 1, 2);
    cyc();
    set_op(0, 6, 3, 0);
    commit_valid = 1'b1; commit_wr = 1'b1; commit_rd = 4'd3;
    cyc();
    idle();
    chk("s4_byp_b", 32'(iss.out_rs1_busy), 0);
    chk("s4_byp_r", 32'(iss.out_rs1), 3);
    chk("s4_byp_b2", 32'(iss.out_rs2_busy), 0);
    chk("s4_byp_tag", 32'(iss.out_tag), 1);
    chk("s4_byp_cnt", 32'(rob_count), 1);
    set_op(0, 9, 3, 6);
    cyc();
    idle();
    chk("s4_clr_b", 32'(iss.out_rs1_busy), 0);
    chk("s4_r6_b", 32'(iss.out_rs2_busy), 1);
    chk("s4_r6_t", 32'(iss.out_rs2), 1);

    // r3 renamed to tag 5 before tag 0 retires: stays busy on tag 5
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_op(0, (i == 0 || i == 5) ? 3 : 7, 1, 1);
      rel_add = 1'b1;
      cyc();
    end
    set_op(0, 8, 3, 1);
    commit_valid = 1'b1; commit_wr = 1'b1; commit_rd = 4'd3;
    cyc();
    idle();
    chk("s4_ren_b", 32'(iss.out_rs1_busy), 1);
    chk("s4_ren_t", 32'(iss.out_rs1), 5);
    chk("s4_ren_tag", 32'(iss.out_tag), 6);
    chk("s4_ren_cnt", 32'(rob_count), 6);

    // reserved opcode consumes no tag
    set_op(15, 2, 0, 0);
    cyc();
    idle();
    chk("s5_ill", 32'(iss.illegal), 1);
    chk("s5_nov", 32'(iss.out_valid), 0);
    chk("s5_cnt", 32'(rob_count), 6);
    set_op(0, 2, 0, 0);
    rel_add = 1'b1;
    cyc();
    idle();
    chk("s5_illoff", 32'(iss.illegal), 0);
    chk("s5_tag", 32'(iss.out_tag), 7);
    chk("s5_cnt7", 32'(rob_count), 7);

    // flush with five in flight and add credits exhausted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_op((i < 3) ? 0 : 2, 3, 1, 2);
      cyc();
    end
    chk("s6_cnt5", 32'(rob_count), 5);
    set_op(0, 1, 3, 4);
    #1 chk("s6_nocred", 32'(iss.in_ready), 0);
    set_op(2, 1, 3, 4);
    flush = 1'b1;
    #1 chk("s6_flrdy", 32'(iss.in_ready), 0);
    cyc();
    flush = 1'b0;
    chk("s6_cnt0", 32'(rob_count), 0);
    chk("s6_nov", 32'(iss.out_valid), 0);
    set_op(0, 1, 3, 4);
    #1 chk("s6_rdy", 32'(iss.in_ready), 1);
    cyc();
    chk("s6_tag", 32'(iss.out_tag), 0);
    chk("s6_b1", 32'(iss.out_rs1_busy), 0);
    chk("s6_rs1", 32'(iss.out_rs1), 3);

    // asynchronous reset mid-stream
    set_op(0, 5, 1, 2);
    cyc();
    chk("s7_pre", 32'(iss.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("s7_valid", 32'(iss.out_valid), 0);
    chk("s7_tag", 32'(iss.out_tag), 0);
    chk("s7_cnt", 32'(rob_count), 0);
    chk("s7_rs1", 32'(iss.out_rs1), 0);
    chk("s7_rd", 32'(iss.out_rd), 0);
    idle();
    #1 rst_n = 1'b1;
    #1 chk("s7_rdy", 32'(iss.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
